// File: rtl/my_button_debouncer.sv
// my_button_debouncer
// Per-channel synchroniser and debouncer for raw button/switch pins. A channel
// only changes its registered output after the synchronised level has differed
// from it for STABLE_CYCLES consecutive clocks; any return to the current
// output value discards the accumulated count. A one-cycle toggle pulse is
// registered alongside each accepted change.
module my_button_debouncer #(
    parameter int SIGNAL_NUMBER    = 3,
    parameter int SYNC_STAGES      = 2,
    parameter int STABLE_CYCLES    = 250000,
    parameter int INPUT_ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SIGNAL_NUMBER-1:0] signal_input,
    output logic [SIGNAL_NUMBER-1:0] signal_output,
    output logic [SIGNAL_NUMBER-1:0] signal_toggle
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // Terminal count: reaching it with a still-differing level accepts the level.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SIGNAL_NUMBER-1:0]                  x;
    logic [SIGNAL_NUMBER-1:0]                  s;
    logic [SYNC_STAGES-1:0][SIGNAL_NUMBER-1:0] sync_q, sync_d;
    logic [SIGNAL_NUMBER-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [SIGNAL_NUMBER-1:0]                  out_q, out_d;
    logic [SIGNAL_NUMBER-1:0]                  tog_q, tog_d;

    // Normalise polarity so that 1 always means "pressed" inside the block.
    generate
        if (INPUT_ACTIVE_LOW != 0) begin : g_inv
            assign x = ~signal_input;
        end else begin : g_pass
            assign x = signal_input;
        end
    endgenerate

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 captures the asynchronous pins, last stage is s.
    always_comb begin
        sync_d    = '0;
        sync_d[0] = x;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Per-channel stability counter, output acceptance and toggle generation.
    always_comb begin
        cnt_d = '0;
        out_d = out_q;
        tog_d = '0;
        for (int i = 0; i < SIGNAL_NUMBER; i++) begin
            if (s[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    out_d[i] = s[i];
                    tog_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State registers; reset returns every channel to released with no count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            tog_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tog_q  <= tog_d;
        end
    end

    assign signal_output = out_q;
    assign signal_toggle = tog_q;

endmodule

// File: tb/tb_my_button_debouncer.sv
// Testbench for my_button_debouncer: hand-derived vector table, a mid-count
// reset sequence, then randomized pins checked against a sliding-window model.
module tb_my_button_debouncer;

    localparam int N  = 3;
    localparam int SS = 2;
    localparam int SC = 4;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic [N-1:0] pins = 3'b111;
    logic [N-1:0] sout;
    logic [N-1:0] stog;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    my_button_debouncer #(
        .SIGNAL_NUMBER   (N),
        .SYNC_STAGES     (SS),
        .STABLE_CYCLES   (SC),
        .INPUT_ACTIVE_LOW(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signal_input (pins),
        .signal_output(sout),
        .signal_toggle(stog)
    );

    // Reference model: the synchronised level is the pressed-state sampled
    // SS edges earlier; a channel flips when the last SC synchronised samples
    // all disagree with its current output.
    logic [N-1:0] pipe[$];
    logic [N-1:0] win[$];
    logic [N-1:0] mout;
    logic [N-1:0] mtog;
    logic [N-1:0] s_pre;
    bit           all_diff;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pipe = {};
                for (int k = 0; k < SS; k++) pipe.push_back('0);
                win  = {};
                mout = '0;
                mtog = '0;
            end else begin
                s_pre = pipe.pop_front();
                pipe.push_back(~pins);
                win.push_back(s_pre);
                if (win.size() > SC) void'(win.pop_front());
                mtog = '0;
                if (win.size() == SC) begin
                    for (int i = 0; i < N; i++) begin
                        all_diff = 1'b1;
                        foreach (win[j]) if (win[j][i] == mout[i]) all_diff = 1'b0;
                        if (all_diff) begin
                            mout[i] = ~mout[i];
                            mtog[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    typedef struct {
        logic [N-1:0] pins;
        logic [N-1:0] eo;
        logic [N-1:0] et;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] p, input logic [N-1:0] eo,
                       input logic [N-1:0] et, input int n);
        vec_t v;
        v.pins = p;
        v.eo   = eo;
        v.et   = et;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive pins, let one rising edge sample them, then settle away from the edge.
    task automatic step(input logic [N-1:0] p);
        pins = p;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // 1: idle, nothing pressed
        add(3'b111, 3'b000, 3'b000, 10);
        // 2: press pin0
        add(3'b110, 3'b000, 3'b000, 5);
        add(3'b110, 3'b001, 3'b001, 1);
        add(3'b110, 3'b001, 3'b000, 2);
        // 3: 3-cycle glitch on pin1
        add(3'b100, 3'b001, 3'b000, 3);
        add(3'b110, 3'b001, 3'b000, 4);
        // 4: bounce on pin2: 0,1,0,0,...
        add(3'b010, 3'b001, 3'b000, 1);
        add(3'b110, 3'b001, 3'b000, 1);
        add(3'b010, 3'b001, 3'b000, 5);
        add(3'b010, 3'b101, 3'b100, 1);
        add(3'b010, 3'b101, 3'b000, 3);
        // release pins 0 and 2 together
        add(3'b111, 3'b101, 3'b000, 5);
        add(3'b111, 3'b000, 3'b101, 1);
        add(3'b111, 3'b000, 3'b000, 1);
        // 5: press pins 0 and 1 together, then release pin0 only
        add(3'b100, 3'b000, 3'b000, 5);
        add(3'b100, 3'b011, 3'b011, 1);
        add(3'b100, 3'b011, 3'b000, 1);
        add(3'b101, 3'b011, 3'b000, 5);
        add(3'b101, 3'b010, 3'b001, 1);
        add(3'b101, 3'b010, 3'b000, 1);
        // release pin1
        add(3'b111, 3'b010, 3'b000, 5);
        add(3'b111, 3'b000, 3'b010, 1);
        add(3'b111, 3'b000, 3'b000, 1);

        // Reset held with all pins released
        rst  = 1'b0;
        pins = 3'b111;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out", sout, 3'b000);
        chk("reset_tog", stog, 3'b000);
        rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].pins);
            chk($sformatf("vec%0d_out", i), sout, tbl[i].eo);
            chk($sformatf("vec%0d_tog", i), stog, tbl[i].et);
        end

        // 6: reset while pin0's count is at 2, then re-qualify from scratch
        for (int k = 0; k < 4; k++) begin
            step(3'b110);
            chk($sformatf("pre_rst%0d_out", k), sout, 3'b000);
        end
        #1 rst = 1'b0;
        #1;
        chk("async_rst_out", sout, 3'b000);
        chk("async_rst_tog", stog, 3'b000);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_hold_out", sout, 3'b000);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(3'b110);
            chk($sformatf("post_rst%0d_out", k), sout, (k == 5) ? 3'b001 : 3'b000);
            chk($sformatf("post_rst%0d_tog", k), stog, (k == 5) ? 3'b001 : 3'b000);
        end
        step(3'b110);
        chk("post_rst_hold_out", sout, 3'b001);
        chk("post_rst_hold_tog", stog, 3'b000);

        // Randomized pins, with one asynchronous reset pulse mid-run
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] p;
            p = pins;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 6) == 0) p[b] = ~p[b];
            end
            if (c == 900) rst = 1'b0;
            if (c == 903) rst = 1'b1;
            step(p);
            chk($sformatf("rnd%0d_out", c), sout, mout);
            chk($sformatf("rnd%0d_tog", c), stog, mtog);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
